// File: rtl/shifter_seq32.sv
// Multi-cycle shifter with start/done handshake: SRA/SRL/SLL, one position per clock.
// Define SHIFT_FAST4_EN to shift four positions per clock while at least four remain.
module shifter_seq32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [4:0]       b,
  input  logic [1:0]       aluc,
  output logic [WIDTH-1:0] c,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [2:0]       step;

  // aluc encoding: 00 arithmetic right, 01 logical right, 1x logical left.
  function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] val,
                                                input logic [1:0] op,
                                                input logic [2:0] amt);
    logic [WIDTH-1:0] res;
    unique case (op)
      2'b00:   res = WIDTH'($signed(val) >>> amt);
      2'b01:   res = val >> amt;
      default: res = val << amt;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    step    = 3'd1;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          acc_d   = a;
          cnt_d   = b;
          op_d    = aluc;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (cnt_q == 5'd0) begin
          state_d = StDone;
        end else begin
`ifdef SHIFT_FAST4_EN
          if (cnt_q >= 5'd4) step = 3'd4;
`endif
          acc_d = shift_by(acc_q, op_q, step);
          cnt_d = cnt_q - {2'b00, step};
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  assign c    = acc_q;
  assign busy = (state_q == StShift);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_shifter_seq32.sv
// Self-checking bench for shifter_seq32: directed vectors plus randomized ops against a
// behavioural model (define SHIFT_FAST4_EN here too when testing the fast-step build).
module tb_shifter_seq32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  b;
  logic [1:0]  aluc;
  logic [31:0] c;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  shifter_seq32 #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .aluc (aluc),
    .c    (c),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_shift(input logic [31:0] x, input int n,
                                              input logic [1:0] op);
    if (op == 2'b00) return 32'($signed(x) >>> n);
    if (op == 2'b01) return x >> n;
    return x << n;
  endfunction

  function automatic int model_latency(input int n);
`ifdef SHIFT_FAST4_EN
    return n / 4 + n % 4 + 1;
`else
    return n + 1;
`endif
  endfunction

  // Entered and left at a negedge; on return the DUT is in its DONE cycle with start low.
  task automatic do_op(input logic [31:0] aa, input logic [4:0] bb, input logic [1:0] op,
                       input bit noisy_start, input string tag);
    int k;
    int busy_cnt;
    a = aa; b = bb; aluc = op; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = 5'($urandom); aluc = 2'($urandom);
    check_val({tag, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    k = 0;
    busy_cnt = 0;
    while (!done && k < 40) begin
      if (busy) begin
        busy_cnt++;
        if (noisy_start) start = 1'($urandom);
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check_val({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    check_val({tag, "_latency"}, k, model_latency(int'(bb)));
    check_val({tag, "_busy_cycles"}, busy_cnt, model_latency(int'(bb)));
    check_val({tag, "_result"}, c, model_shift(aa, int'(bb), op));
  endtask

  task automatic idle_check(input string tag, input logic [31:0] exp_c);
    @(negedge clk);
    check_val({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check_val({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_c_hold"}, c, exp_c);
  endtask

  initial begin
    int dcount;
    logic [31:0] ra;
    logic [4:0]  rb;
    logic [1:0]  rop;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; aluc = '0;
    repeat (3) @(negedge clk);
    check_val("reset_c", c, 32'h0);
    check_val("reset_busy", {31'd0, busy}, 32'd0);
    check_val("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(32'hFEEE1234, 5'd10, 2'b00, 1'b0, "sra10");
    check_val("sra10_vec", c, 32'hFFFFBB84);
    idle_check("sra10_idle", 32'hFFFFBB84);

    do_op(32'hE10381AB, 5'd2, 2'b01, 1'b0, "srl2");
    check_val("srl2_vec", c, 32'h3840E06A);
    do_op(32'h80B29E20, 5'd5, 2'b10, 1'b0, "b2b_sll5");
    check_val("sll5_vec", c, 32'h1653C400);
    idle_check("sll5_idle", 32'h1653C400);

    do_op(32'h12345678, 5'd0, 2'b00, 1'b0, "zero");
    check_val("zero_vec", c, 32'h12345678);
    idle_check("zero_idle", 32'h12345678);

    do_op(32'h87654321, 5'd31, 2'b00, 1'b1, "noisy31");
    @(negedge clk);
    check_val("noisy31_single_done", {31'd0, done}, 32'd0);
    check_val("noisy31_no_restart", {31'd0, busy}, 32'd0);

    do_op(32'hC019AD39, 5'd27, 2'b11, 1'b0, "sll27");
    check_val("sll27_vec", c, 32'hC8000000);
    idle_check("sll27_idle", 32'hC8000000);

    // Reset aborts mid-shift with no done pulse.
    a = 32'hDEADBEEF; b = 5'd20; aluc = 2'b01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("abort_c", c, 32'h0);
    check_val("abort_busy", {31'd0, busy}, 32'd0);
    check_val("abort_done", {31'd0, done}, 32'd0);
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check_val("abort_no_done", dcount, 0);
    do_op(32'hA5A5F00F, 5'd7, 2'b00, 1'b0, "after_abort");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = 5'($urandom); rop = 2'($urandom);
      do_op(ra, rb, rop, 1'($urandom), "rand");
      if ($urandom_range(0, 1) == 0) idle_check("rand_idle", model_shift(ra, int'(rb), rop));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
